fpu_mul_scheduler: RTL and testbench
====================================

# fpu_mul_scheduler

Round-robin scheduler that shares one sequential mantissa multiplier (`fpuMultiplier16`) among `NREQ` requesters. It sits between the FPU issue logic and the multiplier. It accepts operand pairs over valid/ready channels, generates the multiplier's one-cycle start pulse and its mandatory clear/reset between operations, and returns each product tagged with the requester ID on a single response channel.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; must be ≥2.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `reqValid`, in, `NREQ`: requester i has an operand pair pending.
- `reqA`, in, `NREQ` × `FP16_FRACW`: mantissa A per requester.
- `reqB`, in, `NREQ` × `FP16_FRACW`: mantissa B per requester.
- `reqReady`, out, `NREQ`: one-hot accept strobe.
- `respValid`, out, 1: product available.
- `respId`, out, `IDW`: requester that owns the product.
- `respProduct`, out, 2 × `FP16_FRACW`: unsigned product A × B.
- `respReady`, in, 1: consumer takes the response.
- `busy`, out, 1: high in every state except IDLE.

## Operation
The block is a five-state FSM: IDLE, LAUNCH, COMPUTE, RESP, CLEAR.

- **IDLE**
  - If any `reqValid` is high, grant the first requester at or after `rrPtr` (searching upward and wrapping to 0).
  - Assert `reqReady[g]` for that one cycle.
  - Latch `reqA[g]`, `reqB[g]` and `g` into the operand and ID registers.
  - Set `rrPtr` to (g+1) mod `NREQ`, then go to LAUNCH.
  - If no request is valid, stay in IDLE.
- **LAUNCH**
  - Drive multiplier `start` = 1 for exactly this cycle.
  - Multiplier inputs come from the operand registers, which are stable through the whole operation.
  - Go to COMPUTE.
- **COMPUTE**
  - Wait for the multiplier's `done`.
  - On `done`, register `mulOut` into `respProduct` and go to RESP.
- **RESP**
  - Hold `respValid` = 1 with `respId` and `respProduct` stable.
  - When `respReady` is high, go to CLEAR.
  - Backpressure may last indefinitely.
- **CLEAR**
  - Drive multiplier `reset` = 1 for one cycle. The multiplier stays in its DONE state until it is reset.
  - Go to IDLE.

Rules:
- Only one operation is in flight at a time. No `reqReady` is asserted outside IDLE.
- The multiplier's `reset` pin is `reset` OR (state == CLEAR), and it is generated from a registered state bit.
- `reqValid` dropping after the grant has no effect.
- Operands are unsigned. The product is the full 2 × `FP16_FRACW` bits with no rounding or truncation.

## Timing
- Reset values:
  - state = IDLE, `rrPtr` = 0.
  - `reqReady`, `respValid`, `busy` = 0.
  - `respId`, `respProduct` = 0.
  - Operand registers = 0.
- Accept (cycle 0) → `start` (cycle 1) → multiplier `done` after M cycles → `respValid` on the cycle after `done` → CLEAR on the cycle after `respReady` → IDLE.
- Minimum issue-to-issue interval is M + 4 cycles.
- `respValid` rises registered, one cycle after `done`.
- `reqReady` is combinational from state, `reqValid` and `rrPtr`.
- Simultaneous requests: exactly one grant per IDLE cycle, in round-robin order.
- A requester that holds `reqValid` is served within `NREQ` operations.
- `rrPtr` wrap: after granting `NREQ`-1 the pointer goes to 0.
- Reset asserted mid-operation, in any state:
  - Immediate return to IDLE; all outputs take their reset values.
  - The in-flight result is discarded and no response is produced.
  - The multiplier is reset by the same signal.

## Structure
- Shared package `fpu_pkg`: typedef `fpuMulSchedState_t` (IDLE, LAUNCH, COMPUTE, RESP, CLEAR).
- `FP16_FRACW` stays in `constants.sv`.
- One natural sub-module: `fpu_rr_arbiter`, parameterised on `NREQ`.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and encoded index.
- The multiplier is instantiated directly as `fpuMultiplier16`.

## Test plan
- **Single request:** requester 2 sends A=3, B=5 with `respReady` held high → `reqReady[2]` pulses once, `start` pulses once, then `respValid` with `respId`=2 and `respProduct`=15; one cycle of multiplier reset follows, then IDLE.
- **All four requesters valid from reset:** operands Ai=i+1, Bi=7 → responses in order ID 0, 1, 2, 3 with products 7, 14, 21, 28; `rrPtr` ends at 0.
- **Backpressure:** `respReady` held low for 20 cycles → `respValid`, `respId` and `respProduct` stay constant, no `reqReady` pulses, the multiplier is not cleared, and a held request is granted only after the response is accepted.
- **Fairness:** requester 0 continuously valid, requester 3 raises `reqValid` mid-operation → requester 3 is granted at the next IDLE, ahead of a second grant to 0.
- **Reset mid-COMPUTE:** `reset` pulsed 3 cycles after `start` → all outputs 0 immediately, no response emitted; the next request (A=max, B=max) returns the exact full-width product.
- **Operand change after grant:** requester inputs changed the cycle after `reqReady` → the product reflects the latched values.

Source files
------------

// File: rtl/constants.sv
// Shared numeric constants for the FPU datapath.
package constants;

    // Significand width of a half-precision operand, hidden bit included.
    localparam int FP16_FRACW = 11;

endpackage

// File: rtl/fpu_pkg.sv
// FPU shared types: scheduler state encoding and small index helpers.
package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        COMPUTE = 3'd2,
        RESP    = 3'd3,
        CLEAR   = 3'd4
    } fpuMulSchedState_t;

    // Wrap an index that is known to be below 2*n back into [0, n).
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/fpuMultiplier16.sv
// Sequential shift-add mantissa multiplier. One start pulse launches an
// operation; done stays high until the block is reset.
module fpuMultiplier16
    import constants::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [FP16_FRACW-1:0]   a,
    input  logic [FP16_FRACW-1:0]   b,
    output logic [2*FP16_FRACW-1:0] mulOut,
    output logic                    done
);

    localparam int W  = FP16_FRACW;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mul_state_t;

    mul_state_t       st_q, st_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // One partial product per cycle, LSB of the multiplier first.
    always_comb begin
        st_d     = st_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (st_q)
            M_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = {{W{1'b0}}, a};
                    mplier_d = b;
                    cnt_d    = '0;
                    st_d     = M_BUSY;
                end
            end
            M_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    st_d = M_DONE;
                end
            end
            default: ;
        endcase
    end

    // Multiplier state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q     <= M_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            st_q     <= st_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mulOut = acc_q;
    assign done   = (st_q == M_DONE);

endmodule

// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping to 0.
module fpu_rr_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Scan upward from the pointer; the first hit wins and masks the rest.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[rr_wrap(int'(ptr) + k, NREQ)]) begin
                any = 1'b1;
                gnt[rr_wrap(int'(ptr) + k, NREQ)] = 1'b1;
                idx = IDW'(rr_wrap(int'(ptr) + k, NREQ));
            end
        end
    end

endmodule

// File: rtl/fpu_mul_scheduler.sv
// Round-robin scheduler sharing one sequential mantissa multiplier among
// NREQ requesters; one operation in flight, tagged response channel.
module fpu_mul_scheduler
    import constants::*;
    import fpu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NREQ-1:0]                     reqValid,
    input  logic [NREQ-1:0][FP16_FRACW-1:0]     reqA,
    input  logic [NREQ-1:0][FP16_FRACW-1:0]     reqB,
    output logic [NREQ-1:0]                     reqReady,
    output logic                                respValid,
    output logic [IDW-1:0]                      respId,
    output logic [2*FP16_FRACW-1:0]             respProduct,
    input  logic                                respReady,
    output logic                                busy
);

    localparam int W = FP16_FRACW;

    fpuMulSchedState_t state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [W-1:0]      op_a_q, op_a_d;
    logic [W-1:0]      op_b_q, op_b_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [2*W-1:0]    prod_q, prod_d;
    logic              clear_q, clear_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IDW-1:0]    arb_idx;
    logic              arb_any;

    logic              mul_start;
    logic              mul_reset;
    logic [2*W-1:0]    mul_out;
    logic              mul_done;

    fpu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req (reqValid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    fpuMultiplier16 u_mul (
        .clock  (clock),
        .reset  (mul_reset),
        .start  (mul_start),
        .a      (op_a_q),
        .b      (op_b_q),
        .mulOut (mul_out),
        .done   (mul_done)
    );

    // State, operand, pointer and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            id_q     <= '0;
            prod_q   <= '0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            id_q     <= id_d;
            prod_q   <= prod_d;
            clear_q  <= clear_d;
        end
    end

    // Next-state: grant -> launch -> wait done -> hold response -> clear multiplier.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any)   state_d = LAUNCH;
            LAUNCH:                 state_d = COMPUTE;
            COMPUTE: if (mul_done)  state_d = RESP;
            RESP:    if (respReady) state_d = CLEAR;
            CLEAR:                  state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Datapath updates: latch the granted operands, capture the product, and
    // pre-compute the clear flop so the multiplier reset comes from a register.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        id_d     = id_q;
        prod_d   = prod_q;
        if (state_q == IDLE && arb_any) begin
            op_a_d   = reqA[arb_idx];
            op_b_d   = reqB[arb_idx];
            id_d     = arb_idx;
            rr_ptr_d = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        end
        if (state_q == COMPUTE && mul_done) begin
            prod_d = mul_out;
        end
        clear_d = (state_d == CLEAR);
    end

    // Outputs decoded from the registered state; ready is gated by reset so
    // nothing is accepted while the block is held in reset.
    always_comb begin
        reqReady    = (state_q == IDLE && !reset) ? arb_gnt : '0;
        mul_start   = (state_q == LAUNCH);
        respValid   = (state_q == RESP);
        busy        = (state_q != IDLE);
        respId      = id_q;
        respProduct = prod_q;
    end

    assign mul_reset = reset | clear_q;

endmodule

// File: tb/tb_fpu_mul_scheduler.sv
// Bench for fpu_mul_scheduler: directed scenarios plus randomized traffic
// checked against a round-robin/product reference model.
module tb_fpu_mul_scheduler;
    import constants::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = FP16_FRACW;
    localparam int PW   = 2 * W;

    logic                        clock = 1'b0;
    logic                        reset = 1'b1;
    logic [NREQ-1:0]             reqValid = '0;
    logic [NREQ-1:0][W-1:0]      reqA = '0;
    logic [NREQ-1:0][W-1:0]      reqB = '0;
    logic [NREQ-1:0]             reqReady;
    logic                        respValid;
    logic [IDW-1:0]              respId;
    logic [PW-1:0]               respProduct;
    logic                        respReady = 1'b0;
    logic                        busy;

    int checks   = 0;
    int failures = 0;
    int model_ptr = 0;

    int n_start = 0;
    int n_clear = 0;
    int n_grant = 0;

    fpu_mul_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clock       (clock),
        .reset       (reset),
        .reqValid    (reqValid),
        .reqA        (reqA),
        .reqB        (reqB),
        .reqReady    (reqReady),
        .respValid   (respValid),
        .respId      (respId),
        .respProduct (respProduct),
        .respReady   (respReady),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (dut.mul_start) n_start <= n_start + 1;
        if (dut.mul_reset && !reset) n_clear <= n_clear + 1;
        if (reqReady != '0) n_grant <= n_grant + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: first valid requester at or after the pointer, wrapping.
    function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [PW-1:0] exp_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_grant(output int g, output logic [NREQ-1:0] vec, output bit to);
        g = -1; vec = '0; to = 1'b1;
        #1;
        for (int c = 0; c < 100; c++) begin
            if (reqReady != '0) begin
                vec = reqReady;
                to  = 1'b0;
                for (int i = NREQ - 1; i >= 0; i--) if (reqReady[i]) g = i;
                break;
            end
            step();
        end
    endtask

    task automatic wait_resp(output bit to);
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (respValid) begin
                to = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; reqValid = '0; respReady = 1'b0; reqA = '0; reqB = '0;
        step(); step();
        reset = 1'b0;
        model_ptr = 0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; reqValid = '1; respReady = 1'b1;
        step(); step();
        checks++; if (reqReady !== '0) begin failures++; $display("FAIL reset_reqReady got=%b exp=0", reqReady); end
        checks++; if (respValid !== 1'b0) begin failures++; $display("FAIL reset_respValid got=%b exp=0", respValid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (respId !== '0) begin failures++; $display("FAIL reset_respId got=%0d exp=0", respId); end
        checks++; if (respProduct !== '0) begin failures++; $display("FAIL reset_respProduct got=%0d exp=0", respProduct); end
        reqValid = '0; respReady = 1'b0;
        reset = 1'b0; model_ptr = 0;
        step();
    endtask

    task automatic test_single();
        int g; logic [NREQ-1:0] vec; bit to; int s0, c0, g0;
        s0 = n_start; c0 = n_clear; g0 = n_grant;
        reqValid = 4'b0100; reqA[2] = W'(3); reqB[2] = W'(5); respReady = 1'b1;
        wait_grant(g, vec, to);
        checks++; if (to || vec !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", vec); end
        model_ptr = (exp_grant(4'b0100, model_ptr) + 1) % NREQ;
        step();
        reqValid = '0;
        wait_resp(to);
        checks++; if (to || respId !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2 timeout=%0d", respId, to); end
        checks++; if (respProduct !== PW'(15)) begin failures++; $display("FAIL single_product got=%0d exp=15", respProduct); end
        step();
        checks++; if (busy !== 1'b1 || respValid !== 1'b0) begin failures++; $display("FAIL single_clear_state busy=%b respValid=%b exp=1,0", busy, respValid); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle busy=%b exp=0", busy); end
        step();
        checks++; if (n_grant - g0 != 1) begin failures++; $display("FAIL single_grant_count got=%0d exp=1", n_grant - g0); end
        checks++; if (n_start - s0 != 1) begin failures++; $display("FAIL single_start_count got=%0d exp=1", n_start - s0); end
        checks++; if (n_clear - c0 != 1) begin failures++; $display("FAIL single_clear_count got=%0d exp=1", n_clear - c0); end
    endtask

    task automatic test_all_four();
        int g; logic [NREQ-1:0] vec; bit to;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin reqA[i] = W'(i + 1); reqB[i] = W'(7); end
        reqValid = '1; respReady = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            wait_grant(g, vec, to);
            checks++; if (to || g != exp_grant(reqValid, model_ptr)) begin failures++; $display("FAIL all4_grant%0d got=%0d exp=%0d", k, g, exp_grant(reqValid, model_ptr)); end
            model_ptr = (exp_grant(reqValid, model_ptr) + 1) % NREQ;
            step();
            wait_resp(to);
            if (k == NREQ - 1) reqValid = '0;
            checks++; if (to || respId !== IDW'(k) || respProduct !== PW'((k + 1) * 7)) begin
                failures++; $display("FAIL all4_resp%0d got id=%0d prod=%0d exp id=%0d prod=%0d", k, respId, respProduct, k, (k + 1) * 7);
            end
            step();
        end
        step();
        checks++; if (dut.rr_ptr_q !== IDW'(model_ptr)) begin failures++; $display("FAIL all4_ptr got=%0d exp=%0d", dut.rr_ptr_q, model_ptr); end
    endtask

    task automatic test_backpressure();
        int g; logic [NREQ-1:0] vec; bit to; int g0, c0; bit bad_hold, bad_rdy;
        logic [PW-1:0] ep; logic [W-1:0] a, b;
        a = W'($urandom); b = W'($urandom);
        reqValid = 4'b0010; reqA[1] = a; reqB[1] = b; respReady = 1'b0;
        wait_grant(g, vec, to);
        checks++; if (to || g != exp_grant(4'b0010, model_ptr)) begin failures++; $display("FAIL bp_grant got=%0d exp=1", g); end
        model_ptr = (exp_grant(4'b0010, model_ptr) + 1) % NREQ;
        ep = exp_prod(a, b);
        step();
        reqValid = 4'b0001; reqA[0] = W'($urandom); reqB[0] = W'($urandom);
        wait_resp(to);
        checks++; if (to || respId !== 2'd1 || respProduct !== ep) begin failures++; $display("FAIL bp_resp got id=%0d prod=%0d exp id=1 prod=%0d", respId, respProduct, ep); end
        g0 = n_grant; c0 = n_clear; bad_hold = 1'b0; bad_rdy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (respValid !== 1'b1 || respId !== 2'd1 || respProduct !== ep) bad_hold = 1'b1;
            if (reqReady !== '0) bad_rdy = 1'b1;
        end
        checks++; if (bad_hold) begin failures++; $display("FAIL bp_hold got valid=%b id=%0d prod=%0d exp 1/1/%0d", respValid, respId, respProduct, ep); end
        checks++; if (bad_rdy || n_grant != g0) begin failures++; $display("FAIL bp_no_grant got=%0d exp=%0d", n_grant, g0); end
        checks++; if (n_clear != c0) begin failures++; $display("FAIL bp_no_clear got=%0d exp=%0d", n_clear, c0); end
        respReady = 1'b1;
        wait_grant(g, vec, to);
        checks++; if (to || g != exp_grant(4'b0001, model_ptr) || respValid !== 1'b0) begin
            failures++; $display("FAIL bp_next_grant got=%0d respValid=%b exp=%0d,0", g, respValid, exp_grant(4'b0001, model_ptr));
        end
        model_ptr = (exp_grant(4'b0001, model_ptr) + 1) % NREQ;
        ep = exp_prod(reqA[0], reqB[0]);
        step();
        reqValid = '0;
        wait_resp(to);
        checks++; if (to || respId !== 2'd0 || respProduct !== ep) begin failures++; $display("FAIL bp_resp2 got id=%0d prod=%0d exp id=0 prod=%0d", respId, respProduct, ep); end
        step(); step();
    endtask

    task automatic test_fairness();
        int g; logic [NREQ-1:0] vec; bit to; logic [PW-1:0] ep0, ep3;
        do_reset();
        reqA[0] = W'($urandom); reqB[0] = W'($urandom);
        reqA[3] = W'($urandom); reqB[3] = W'($urandom);
        ep0 = exp_prod(reqA[0], reqB[0]); ep3 = exp_prod(reqA[3], reqB[3]);
        reqValid = 4'b0001; respReady = 1'b1;
        wait_grant(g, vec, to);
        checks++; if (to || g != 0) begin failures++; $display("FAIL fair_first got=%0d exp=0", g); end
        model_ptr = 1;
        step(); step(); step();
        reqValid = 4'b1001;
        wait_resp(to);
        checks++; if (to || respProduct !== ep0) begin failures++; $display("FAIL fair_resp0 got=%0d exp=%0d", respProduct, ep0); end
        step();
        wait_grant(g, vec, to);
        checks++; if (to || g != exp_grant(4'b1001, model_ptr)) begin failures++; $display("FAIL fair_second got=%0d exp=%0d", g, exp_grant(4'b1001, model_ptr)); end
        model_ptr = (exp_grant(4'b1001, model_ptr) + 1) % NREQ;
        step();
        reqValid = 4'b0001;
        wait_resp(to);
        checks++; if (to || respId !== 2'd3 || respProduct !== ep3) begin failures++; $display("FAIL fair_resp3 got id=%0d prod=%0d exp id=3 prod=%0d", respId, respProduct, ep3); end
        step();
        wait_grant(g, vec, to);
        checks++; if (to || g != exp_grant(4'b0001, model_ptr)) begin failures++; $display("FAIL fair_third got=%0d exp=0", g); end
        model_ptr = (exp_grant(4'b0001, model_ptr) + 1) % NREQ;
        step();
        reqValid = '0;
        wait_resp(to);
        step(); step();
    endtask

    task automatic test_reset_mid();
        int g; logic [NREQ-1:0] vec; bit to; int s0; bit saw_resp;
        reqValid = 4'b0010; reqA[1] = W'($urandom); reqB[1] = W'($urandom); respReady = 1'b1;
        wait_grant(g, vec, to);
        step();
        step(); step(); step();
        reset = 1'b1;
        #1;
        checks++; if (reqReady !== '0 || respValid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rmid_ctrl got rdy=%b valid=%b busy=%b exp 0/0/0", reqReady, respValid, busy);
        end
        checks++; if (respId !== '0 || respProduct !== '0) begin failures++; $display("FAIL rmid_data got id=%0d prod=%0d exp 0/0", respId, respProduct); end
        step();
        reqValid = '0; reset = 1'b0; model_ptr = 0;
        s0 = n_start; saw_resp = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (respValid !== 1'b0) saw_resp = 1'b1;
        end
        checks++; if (saw_resp || n_start != s0) begin failures++; $display("FAIL rmid_no_resp got resp=%b starts=%0d exp 0/0", saw_resp, n_start - s0); end
        reqValid = 4'b0100; reqA[2] = '1; reqB[2] = '1;
        wait_grant(g, vec, to);
        checks++; if (to || g != exp_grant(4'b0100, model_ptr)) begin failures++; $display("FAIL rmid_grant got=%0d exp=2", g); end
        model_ptr = (exp_grant(4'b0100, model_ptr) + 1) % NREQ;
        step();
        reqValid = '0;
        wait_resp(to);
        checks++; if (to || respProduct !== exp_prod('1, '1)) begin failures++; $display("FAIL rmid_maxprod got=%0d exp=%0d", respProduct, exp_prod('1, '1)); end
        step(); step();
    endtask

    task automatic test_operand_change();
        int g; logic [NREQ-1:0] vec; bit to; logic [W-1:0] a, b; logic [PW-1:0] ep;
        a = W'($urandom); b = W'($urandom);
        reqValid = 4'b1000; reqA[3] = a; reqB[3] = b; respReady = 1'b1;
        wait_grant(g, vec, to);
        model_ptr = (exp_grant(4'b1000, model_ptr) + 1) % NREQ;
        ep = exp_prod(a, b);
        step();
        reqA[3] = ~a; reqB[3] = b ^ W'(5); reqValid = '0;
        wait_resp(to);
        checks++; if (to || respId !== 2'd3 || respProduct !== ep) begin failures++; $display("FAIL opchg got id=%0d prod=%0d exp id=3 prod=%0d", respId, respProduct, ep); end
        step(); step();
    endtask

    task automatic test_random();
        int g, eg; logic [NREQ-1:0] vec, v; bit to; logic [PW-1:0] ep; int hold;
        for (int it = 0; it < 40; it++) begin
            v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin reqA[i] = W'($urandom); reqB[i] = W'($urandom); end
            reqValid = v; respReady = 1'($urandom);
            eg = exp_grant(v, model_ptr);
            wait_grant(g, vec, to);
            checks++; if (to || g != eg || vec !== NREQ'(1 << eg)) begin failures++; $display("FAIL rand_grant it=%0d got=%b exp=%0d", it, vec, eg); end
            model_ptr = (eg + 1) % NREQ;
            ep = exp_prod(reqA[eg], reqB[eg]);
            step();
            reqValid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin reqA[i] = W'($urandom); reqB[i] = W'($urandom); end
            wait_resp(to);
            if (!respReady) begin
                hold = $urandom_range(0, 4);
                for (int c = 0; c < hold; c++) step();
                respReady = 1'b1;
            end
            checks++; if (to || respValid !== 1'b1 || respId !== IDW'(eg) || respProduct !== ep) begin
                failures++; $display("FAIL rand_resp it=%0d got id=%0d prod=%0d exp id=%0d prod=%0d", it, respId, respProduct, eg, ep);
            end
            step();
            reqValid = '0;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_operand_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
